// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared types and constants for the main-CPU program-ROM fetch controller.
package rom_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   localparam logic [7:0] ENC_PLAIN      = 8'd0;
   localparam logic [7:0] ENC_FREEZE     = 8'd1;
   localparam logic [7:0] ENC_FREEZE_ALT = 8'd2;

   // Byte returned when the ROM never answers.
   localparam logic [7:0] ROM_FILL = 8'hFF;

endpackage

// File: rtl/rom_fetch_ctrl_if.sv
// Shared ROM port: level request with registered address, one-cycle ack strobe with data.
interface rom_fetch_ctrl_if;

   logic        rom_req;
   logic [15:0] rom_addr;
   logic        rom_ack;
   logic [7:0]  rom_data;

   modport master (
      output rom_req,
      output rom_addr,
      input  rom_ack,
      input  rom_data
   );

   modport slave (
      input  rom_req,
      input  rom_addr,
      output rom_ack,
      output rom_data
   );

endinterface

// File: rtl/rom_fetch_ctrl_decrypt.sv
// Combinational opcode decrypt unit: bit permutation with address-dependent edge bits.
module rom_fetch_ctrl_decrypt
   import rom_fetch_pkg::*;
(
   input  logic [7:0]  mode,
   input  logic [7:0]  raw,
   input  logic [15:0] addr,
   output logic [7:0]  dout
);

   logic       b7;
   logic       b0;
   logic [7:0] perm;
   logic       unused_addr;

   // Address bits 13 and 2 select which end bits swap and whether they invert.
   always_comb begin
      b7 = ~raw[7];
      b0 = ~raw[0];
      if (addr[13]) begin
         if (addr[2]) begin
            b7 = raw[0];
            b0 = raw[7];
         end else begin
            b7 = ~raw[0];
            b0 = ~raw[7];
         end
      end
   end

   assign perm = {b7, raw[2], raw[5], raw[1], raw[3], raw[6], raw[4], b0};
   assign dout = (mode == ENC_FREEZE || mode == ENC_FREEZE_ALT) ? perm : raw;

   assign unused_addr = ^{addr[15:14], addr[12:3], addr[1:0]};

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Serialises CPU program-ROM reads onto the shared ROM port, with M1 decryption and a one-entry cache.
module rom_fetch_ctrl
   import rom_fetch_pkg::*;
#(
   parameter logic [7:0] ENC_DEFAULT = 8'd0,
   parameter int         TIMEOUT     = 255,
   parameter bit         CACHE_EN    = 1'b1
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             cfg_wr,
   input  logic [7:0]       cfg_data,
   input  logic             cpu_rd,
   input  logic             cpu_m1,
   input  logic [15:0]      cpu_addr,
   output logic [7:0]       cpu_din,
   output logic             cpu_wait,
   rom_fetch_ctrl_if.master rom,
   output logic [7:0]       enc_mode,
   output logic             err
);

   localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state;
   state_t        state_next;

   logic [15:0]   addr_q;
   logic          m1_q;
   logic          data_valid;
   logic          cache_valid;
   logic [15:0]   cache_tag;
   logic [7:0]    cache_data;
   logic          pend_valid;
   logic [7:0]    pend_data;
   logic [CW-1:0] tmo_cnt;

   logic          cache_hit;
   logic          timed_out;
   logic          idle_quiet;
   logic          idle_entry;
   logic [7:0]    dec_raw;
   logic [15:0]   dec_addr;
   logic          dec_m1;
   logic [7:0]    dec_out;
   logic [7:0]    dec_byte;

   assign cache_hit  = CACHE_EN && cache_valid && (cpu_addr == cache_tag);
   assign timed_out  = (tmo_cnt == CNT_LAST);
   assign idle_quiet = (state == IDLE) && !cpu_rd;
   assign idle_entry = (state == DONE) && !cpu_rd;
   assign cpu_wait   = cpu_rd & ~data_valid;

   rom_fetch_ctrl_decrypt u_decrypt (
      .mode (enc_mode),
      .raw  (dec_raw),
      .addr (dec_addr),
      .dout (dec_out)
   );

   // The decrypt unit sees the cached byte on a hit and the ROM byte (or fill) on completion.
   assign dec_byte = dec_m1 ? dec_out : dec_raw;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      dec_raw    = cache_data;
      dec_addr   = cpu_addr;
      dec_m1     = cpu_m1;
      case (state)
         IDLE: begin
            if (cpu_rd) begin
               state_next = cache_hit ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            state_next = WAIT;
         end
         WAIT: begin
            dec_raw  = rom.rom_ack ? rom.rom_data : ROM_FILL;
            dec_addr = addr_q;
            dec_m1   = m1_q;
            if (rom.rom_ack || timed_out) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (!cpu_rd) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rom.rom_req  <= 1'b0;
         rom.rom_addr <= 16'h0000;
         cpu_din      <= ROM_FILL;
         data_valid   <= 1'b0;
         cache_valid  <= 1'b0;
         cache_tag    <= 16'h0000;
         cache_data   <= 8'h00;
         addr_q       <= 16'h0000;
         m1_q         <= 1'b0;
         enc_mode     <= ENC_DEFAULT;
         err          <= 1'b0;
         pend_valid   <= 1'b0;
         pend_data    <= 8'h00;
         tmo_cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_rd) begin
                  addr_q <= cpu_addr;
                  m1_q   <= cpu_m1;
                  if (cache_hit) begin
                     cpu_din    <= dec_byte;
                     data_valid <= 1'b1;
                  end else begin
                     rom.rom_addr <= cpu_addr;
                  end
               end
            end
            ISSUE: begin
               rom.rom_req <= 1'b1;
               tmo_cnt     <= '0;
            end
            WAIT: begin
               if (rom.rom_ack) begin
                  cache_tag   <= addr_q;
                  cache_data  <= rom.rom_data;
                  cache_valid <= 1'b1;
                  rom.rom_req <= 1'b0;
                  cpu_din     <= dec_byte;
                  data_valid  <= cpu_rd;
               end else if (timed_out) begin
                  err         <= 1'b1;
                  rom.rom_req <= 1'b0;
                  cpu_din     <= dec_byte;
                  data_valid  <= cpu_rd;
               end else begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            DONE: begin
               if (!cpu_rd) begin
                  data_valid <= 1'b0;
               end
            end
            default: begin
            end
         endcase

         // Mode changes take effect only between reads, and always flush the cache.
         if (cfg_wr && idle_quiet) begin
            enc_mode    <= cfg_data;
            cache_valid <= 1'b0;
         end else if (idle_entry && (cfg_wr || pend_valid)) begin
            enc_mode    <= cfg_wr ? cfg_data : pend_data;
            cache_valid <= 1'b0;
            pend_valid  <= 1'b0;
         end else if (cfg_wr) begin
            pend_valid <= 1'b1;
            pend_data  <= cfg_data;
         end
      end
   end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Scoreboard bench for rom_fetch_ctrl with a delayed-ack ROM responder.
module tb_rom_fetch_ctrl;

   typedef struct {
      logic [7:0]  din;
      int          waits;
      int          reqs;
      logic [15:0] addr;
      bit          chk_addr;
   } exp_t;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        cfg_wr;
   logic [7:0]  cfg_data;
   logic        cpu_rd;
   logic        cpu_m1;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        cpu_wait;
   logic [7:0]  enc_mode;
   logic        err;

   rom_fetch_ctrl_if rom_if ();

   rom_fetch_ctrl #(
      .ENC_DEFAULT (8'd0),
      .TIMEOUT     (8),
      .CACHE_EN    (1'b1)
   ) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .cfg_wr   (cfg_wr),
      .cfg_data (cfg_data),
      .cpu_rd   (cpu_rd),
      .cpu_m1   (cpu_m1),
      .cpu_addr (cpu_addr),
      .cpu_din  (cpu_din),
      .cpu_wait (cpu_wait),
      .rom      (rom_if),
      .enc_mode (enc_mode),
      .err      (err)
   );

   always #5 clk_sys = ~clk_sys;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   exp_t        e;

   int          ack_delay = 0;
   logic [7:0]  ack_data  = 8'h00;
   logic        force_ack = 1'b0;
   int          req_cycles = 0;
   int          req_hi = 0;

   int          obs_waits;
   int          obs_reqs;
   logic [7:0]  obs_din;
   logic [15:0] obs_addr;
   logic [7:0]  mid_mode;

   // ROM model: acks on the ack_delay-th cycle the request is seen high (0 = never).
   always @(negedge clk_sys) begin
      rom_if.rom_ack  = 1'b0;
      rom_if.rom_data = 8'h00;
      if (force_ack) begin
         rom_if.rom_ack  = 1'b1;
         rom_if.rom_data = 8'hC3;
      end else if (rom_if.rom_req === 1'b1) begin
         req_cycles++;
         req_hi++;
         if (ack_delay != 0 && req_cycles == ack_delay) begin
            rom_if.rom_ack  = 1'b1;
            rom_if.rom_data = ack_data;
         end
      end else begin
         req_cycles = 0;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic run_read(input logic [15:0] a, input logic m1, input logic [7:0] d, input int delay);
      int guard;
      int req_start;
      ack_delay = delay;
      ack_data  = d;
      @(posedge clk_sys); #1;
      req_start = req_hi;
      cpu_addr  = a;
      cpu_m1    = m1;
      cpu_rd    = 1'b1;
      obs_waits = 0;
      guard     = 0;
      @(negedge clk_sys);
      while (cpu_wait === 1'b1 && guard < 100) begin
         obs_waits++;
         guard++;
         @(negedge clk_sys);
      end
      obs_din  = cpu_din;
      obs_reqs = req_hi - req_start;
      obs_addr = rom_if.rom_addr;
      @(posedge clk_sys); #1;
      cpu_rd = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
   endtask

   task automatic cfg_write(input logic [7:0] v);
      @(posedge clk_sys); #1;
      cfg_wr   = 1'b1;
      cfg_data = v;
      @(posedge clk_sys); #1;
      cfg_wr   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      @(negedge clk_sys);
      checks++; if (cpu_din !== 8'hFF) begin errors++; $display("[TB] FAIL reset cpu_din got %h want ff", cpu_din); end
      checks++; if (rom_if.rom_req !== 1'b0) begin errors++; $display("[TB] FAIL reset rom_req got %b want 0", rom_if.rom_req); end
      checks++; if (rom_if.rom_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset rom_addr got %h want 0000", rom_if.rom_addr); end
      checks++; if (enc_mode !== 8'h00) begin errors++; $display("[TB] FAIL reset enc_mode got %h want 00", enc_mode); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset err got %b want 0", err); end
      checks++; if (cpu_wait !== 1'b0) begin errors++; $display("[TB] FAIL reset cpu_wait got %b want 0", cpu_wait); end
   endtask

   task automatic test_m1_miss();
      cfg_write(8'd1);
      @(negedge clk_sys);
      checks++; if (enc_mode !== 8'd1) begin errors++; $display("[TB] FAIL cfg_idle enc_mode got %h want 01", enc_mode); end
      sb.push_back('{8'h93, 5, 3, 16'h0000, 1'b1});
      run_read(16'h0000, 1'b1, 8'h12, 3);
      e = sb.pop_front();
      checks++; if (obs_din !== e.din) begin errors++; $display("[TB] FAIL m1_miss din got %h want %h", obs_din, e.din); end
      checks++; if (obs_waits !== e.waits) begin errors++; $display("[TB] FAIL m1_miss waits got %0d want %0d", obs_waits, e.waits); end
      checks++; if (obs_reqs !== e.reqs) begin errors++; $display("[TB] FAIL m1_miss reqs got %0d want %0d", obs_reqs, e.reqs); end
      checks++; if (obs_addr !== e.addr) begin errors++; $display("[TB] FAIL m1_miss rom_addr got %h want %h", obs_addr, e.addr); end
   endtask

   task automatic test_cache_hit();
      sb.push_back('{8'h12, 1, 0, 16'h0000, 1'b0});
      sb.push_back('{8'h93, 1, 0, 16'h0000, 1'b0});
      for (int i = 0; i < 2; i++) begin
         run_read(16'h0000, (i == 1), 8'hAA, 3);
         e = sb.pop_front();
         checks++; if (obs_din !== e.din) begin errors++; $display("[TB] FAIL hit%0d din got %h want %h", i, obs_din, e.din); end
         checks++; if (obs_waits !== e.waits) begin errors++; $display("[TB] FAIL hit%0d waits got %0d want %0d", i, obs_waits, e.waits); end
         checks++; if (obs_reqs !== e.reqs) begin errors++; $display("[TB] FAIL hit%0d reqs got %0d want %0d", i, obs_reqs, e.reqs); end
      end
   endtask

   task automatic test_addr_swap();
      logic [15:0] addrs [2];
      addrs[0] = 16'h2004;
      addrs[1] = 16'h2000;
      sb.push_back('{8'h80, 3, 1, 16'h2004, 1'b1});
      sb.push_back('{8'h01, 3, 1, 16'h2000, 1'b1});
      for (int i = 0; i < 2; i++) begin
         run_read(addrs[i], 1'b1, 8'h01, 1);
         e = sb.pop_front();
         checks++; if (obs_din !== e.din) begin errors++; $display("[TB] FAIL swap%0d din got %h want %h", i, obs_din, e.din); end
         checks++; if (obs_waits !== e.waits) begin errors++; $display("[TB] FAIL swap%0d waits got %0d want %0d", i, obs_waits, e.waits); end
         checks++; if (obs_addr !== e.addr) begin errors++; $display("[TB] FAIL swap%0d rom_addr got %h want %h", i, obs_addr, e.addr); end
      end
   endtask

   task automatic test_ack_at_timeout();
      sb.push_back('{8'h5A, 10, 8, 16'h1234, 1'b1});
      run_read(16'h1234, 1'b0, 8'h5A, 8);
      e = sb.pop_front();
      checks++; if (obs_din !== e.din) begin errors++; $display("[TB] FAIL ack_edge din got %h want %h", obs_din, e.din); end
      checks++; if (obs_waits !== e.waits) begin errors++; $display("[TB] FAIL ack_edge waits got %0d want %0d", obs_waits, e.waits); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL ack_edge err got %b want 0", err); end
   endtask

   task automatic test_timeout();
      sb.push_back('{8'hFF, 10, 8, 16'h4000, 1'b1});
      sb.push_back('{8'h3C, 4, 2, 16'h4000, 1'b1});
      run_read(16'h4000, 1'b0, 8'h99, 0);
      e = sb.pop_front();
      checks++; if (obs_din !== e.din) begin errors++; $display("[TB] FAIL timeout din got %h want %h", obs_din, e.din); end
      checks++; if (obs_reqs !== e.reqs) begin errors++; $display("[TB] FAIL timeout req_cycles got %0d want %0d", obs_reqs, e.reqs); end
      checks++; if (obs_waits !== e.waits) begin errors++; $display("[TB] FAIL timeout waits got %0d want %0d", obs_waits, e.waits); end
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL timeout err got %b want 1", err); end
      run_read(16'h4000, 1'b0, 8'h3C, 2);
      e = sb.pop_front();
      checks++; if (obs_din !== e.din) begin errors++; $display("[TB] FAIL timeout_reread din got %h want %h", obs_din, e.din); end
      checks++; if (obs_reqs !== e.reqs) begin errors++; $display("[TB] FAIL timeout_reread reqs got %0d want %0d", obs_reqs, e.reqs); end
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got %b want 1", err); end
   endtask

   task automatic test_cfg_pending();
      sb.push_back('{8'h93, 6, 4, 16'h0000, 1'b1});
      sb.push_back('{8'h12, 4, 2, 16'h0000, 1'b1});
      mid_mode = 8'hXX;
      fork
         run_read(16'h0000, 1'b1, 8'h12, 4);
         begin
            int g;
            g = 0;
            @(negedge clk_sys);
            while (rom_if.rom_req !== 1'b1 && g < 20) begin
               g++;
               @(negedge clk_sys);
            end
            cfg_wr   = 1'b1;
            cfg_data = 8'h00;
            @(negedge clk_sys);
            cfg_wr   = 1'b0;
            mid_mode = enc_mode;
         end
      join
      e = sb.pop_front();
      checks++; if (mid_mode !== 8'd1) begin errors++; $display("[TB] FAIL cfg_wait mid enc_mode got %h want 01", mid_mode); end
      checks++; if (obs_din !== e.din) begin errors++; $display("[TB] FAIL cfg_wait din got %h want %h", obs_din, e.din); end
      checks++; if (enc_mode !== 8'd0) begin errors++; $display("[TB] FAIL cfg_idle_apply enc_mode got %h want 00", enc_mode); end
      run_read(16'h0000, 1'b1, 8'h12, 2);
      e = sb.pop_front();
      checks++; if (obs_din !== e.din) begin errors++; $display("[TB] FAIL cfg_flush din got %h want %h", obs_din, e.din); end
      checks++; if (obs_reqs !== e.reqs) begin errors++; $display("[TB] FAIL cfg_flush reqs got %0d want %0d", obs_reqs, e.reqs); end
      checks++; if (obs_waits !== e.waits) begin errors++; $display("[TB] FAIL cfg_flush waits got %0d want %0d", obs_waits, e.waits); end
   endtask

   task automatic test_rd_drop();
      int g;
      ack_delay = 3;
      ack_data  = 8'h77;
      @(posedge clk_sys); #1;
      cpu_addr = 16'h0100;
      cpu_m1   = 1'b0;
      cpu_rd   = 1'b1;
      g = 0;
      @(negedge clk_sys);
      while (rom_if.rom_req !== 1'b1 && g < 20) begin g++; @(negedge clk_sys); end
      cpu_rd = 1'b0;
      g = 0;
      while (rom_if.rom_req !== 1'b0 && g < 20) begin g++; @(negedge clk_sys); end
      checks++; if (g >= 20) begin errors++; $display("[TB] FAIL rd_drop rom_req still %b want 0", rom_if.rom_req); end
      sb.push_back('{8'h77, 1, 0, 16'h0100, 1'b0});
      run_read(16'h0100, 1'b0, 8'hEE, 3);
      e = sb.pop_front();
      checks++; if (obs_din !== e.din) begin errors++; $display("[TB] FAIL rd_drop_hit din got %h want %h", obs_din, e.din); end
      checks++; if (obs_waits !== e.waits) begin errors++; $display("[TB] FAIL rd_drop_hit waits got %0d want %0d", obs_waits, e.waits); end
      checks++; if (obs_reqs !== e.reqs) begin errors++; $display("[TB] FAIL rd_drop_hit reqs got %0d want %0d", obs_reqs, e.reqs); end
   endtask

   task automatic test_reset_mid();
      int g;
      ack_delay = 0;
      @(posedge clk_sys); #1;
      cpu_addr = 16'h0200;
      cpu_m1   = 1'b0;
      cpu_rd   = 1'b1;
      g = 0;
      @(negedge clk_sys);
      while (rom_if.rom_req !== 1'b1 && g < 20) begin g++; @(negedge clk_sys); end
      reset  = 1'b1;
      cpu_rd = 1'b0;
      @(negedge clk_sys);
      checks++; if (rom_if.rom_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid rom_req got %b want 0", rom_if.rom_req); end
      reset = 1'b0;
      @(posedge clk_sys); #1;
      force_ack = 1'b1;
      @(posedge clk_sys); #1;
      force_ack = 1'b0;
      repeat (2) @(negedge clk_sys);
      checks++; if (cpu_din !== 8'hFF) begin errors++; $display("[TB] FAIL late_ack cpu_din got %h want ff", cpu_din); end
      checks++; if (rom_if.rom_req !== 1'b0) begin errors++; $display("[TB] FAIL late_ack rom_req got %b want 0", rom_if.rom_req); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid err got %b want 0", err); end
      sb.push_back('{8'h55, 3, 1, 16'h0100, 1'b1});
      run_read(16'h0100, 1'b0, 8'h55, 1);
      e = sb.pop_front();
      checks++; if (obs_din !== e.din) begin errors++; $display("[TB] FAIL post_reset din got %h want %h", obs_din, e.din); end
      checks++; if (obs_reqs !== e.reqs) begin errors++; $display("[TB] FAIL post_reset reqs got %0d want %0d", obs_reqs, e.reqs); end
   endtask

   initial begin
      reset    = 1'b1;
      cfg_wr   = 1'b0;
      cfg_data = 8'h00;
      cpu_rd   = 1'b0;
      cpu_m1   = 1'b0;
      cpu_addr = 16'h0000;
      test_reset();
      test_m1_miss();
      test_cache_hit();
      test_addr_swap();
      test_ack_at_timeout();
      test_timeout();
      test_cfg_pending();
      test_rd_drop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
